// File: rtl/ps2_keyboard_fifo_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver with event FIFO.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } dec_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

endpackage

// File: rtl/ps2_keyboard_fifo_if.sv
// Consumer-side bus of the keyboard FIFO: pop/clear requests in, head event and status out.
interface ps2_keyboard_fifo_if #(
    parameter int unsigned FIFO_DEPTH = 8
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             rd_en;
    logic             err_clr;
    logic [9:0]       data;
    logic             ready;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             parity_err;
    logic             frame_err;

    modport slave (
        input  rd_en, err_clr,
        output data, ready, count, overflow, parity_err, frame_err
    );

    modport master (
        output rd_en, err_clr,
        input  data, ready, count, overflow, parity_err, frame_err
    );
endinterface

// File: rtl/ps2_keyboard_fifo_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, 11-bit deserialiser,
// start/stop/odd-parity checks and a stall timeout that discards partial frames.
module ps2_frame_rx #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       i_clk,
    input  logic       i_clr,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_parity_err_p,
    output logic       o_frame_err_p
);
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_prev;
    logic [3:0]             r_bit_cnt;
    logic [9:0]             r_shift;
    logic [TO_W-1:0]        r_to_cnt;
    logic [7:0]             r_byte;
    logic                   r_byte_valid;
    logic                   r_parity_err_p;
    logic                   r_frame_err_p;

    logic w_clk_s;
    logic w_data_s;
    logic w_fall;

    assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
    assign w_data_s = r_data_sync[SYNC_STAGES-1];
    assign w_fall   = r_clk_prev & ~w_clk_s;

    // Synchroniser chains; reset to 1 so a cleared receiver sees an idle bus.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data};
        end
    end

    // Bit capture on each falling edge, frame check on the stop bit, stall timeout.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_clk_prev     <= 1'b1;
            r_bit_cnt      <= '0;
            r_shift        <= '0;
            r_to_cnt       <= '0;
            r_byte         <= '0;
            r_byte_valid   <= 1'b0;
            r_parity_err_p <= 1'b0;
            r_frame_err_p  <= 1'b0;
        end else begin
            r_clk_prev     <= w_clk_s;
            r_byte_valid   <= 1'b0;
            r_parity_err_p <= 1'b0;
            r_frame_err_p  <= 1'b0;
            if (w_fall) begin
                r_to_cnt <= '0;
                if (r_bit_cnt == 4'd10) begin
                    // Stop bit is the live sample; bits 0..9 are in the shift register.
                    r_bit_cnt <= '0;
                    if (r_shift[0] || !w_data_s) begin
                        r_frame_err_p <= 1'b1;
                    end else if (!(^r_shift[9:1])) begin
                        r_parity_err_p <= 1'b1;
                    end else begin
                        r_byte       <= r_shift[8:1];
                        r_byte_valid <= 1'b1;
                    end
                end else begin
                    r_shift[r_bit_cnt] <= w_data_s;
                    r_bit_cnt          <= r_bit_cnt + 4'd1;
                end
            end else if (r_bit_cnt != 4'd0) begin
                if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    r_bit_cnt     <= '0;
                    r_to_cnt      <= '0;
                    r_frame_err_p <= 1'b1;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    assign o_byte         = r_byte;
    assign o_byte_valid   = r_byte_valid;
    assign o_parity_err_p = r_parity_err_p;
    assign o_frame_err_p  = r_frame_err_p;

endmodule

// File: rtl/ps2_keyboard_fifo.sv
// PS/2 keyboard front end: frame receiver, E0/F0 prefix decoder, FWFT event FIFO
// and sticky error flags.
module ps2_keyboard_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter bit          DECODE_EN      = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_clr,
    input  logic                i_ps2_clk,
    input  logic                i_ps2_data,
    ps2_keyboard_fifo_if.slave  bus
);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [7:0]  w_byte;
    logic        w_byte_valid;
    logic        w_parity_err_p;
    logic        w_frame_err_p;

    dec_state_t  r_state;
    dec_state_t  w_state_d;
    logic        w_push;
    ps2_event_t  w_event;

    ps2_event_t  r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic        r_overflow;
    logic        r_parity_err;
    logic        r_frame_err;

    logic        w_full;
    logic        w_ready;
    logic        w_pop;
    logic        w_wr;

    ps2_frame_rx #(
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .i_clk          (i_clk),
        .i_clr          (i_clr),
        .i_ps2_clk      (i_ps2_clk),
        .i_ps2_data     (i_ps2_data),
        .o_byte         (w_byte),
        .o_byte_valid   (w_byte_valid),
        .o_parity_err_p (w_parity_err_p),
        .o_frame_err_p  (w_frame_err_p)
    );

    // Prefix decoder: folds E0/F0 into ext/brk tags and emits one event per key code.
    always_comb begin
        w_state_d     = r_state;
        w_push        = 1'b0;
        w_event.ext   = 1'b0;
        w_event.brk   = 1'b0;
        w_event.code  = w_byte;
        if (w_byte_valid) begin
            if (!DECODE_EN) begin
                w_push = 1'b1;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (w_byte == PS2_EXT)      w_state_d = EXT;
                        else if (w_byte == PS2_BRK) w_state_d = BRK;
                        else                        w_push    = 1'b1;
                    end
                    EXT: begin
                        if (w_byte == PS2_BRK) begin
                            w_state_d = EXT_BRK;
                        end else if (w_byte != PS2_EXT) begin
                            w_push      = 1'b1;
                            w_event.ext = 1'b1;
                            w_state_d   = IDLE;
                        end
                    end
                    BRK: begin
                        // A stray E0 after F0 is taken as the break code itself.
                        if (w_byte != PS2_BRK) begin
                            w_push      = 1'b1;
                            w_event.brk = 1'b1;
                            w_state_d   = IDLE;
                        end
                    end
                    EXT_BRK: begin
                        w_push      = 1'b1;
                        w_event.ext = 1'b1;
                        w_event.brk = 1'b1;
                        w_state_d   = IDLE;
                    end
                    default: w_state_d = IDLE;
                endcase
            end
        end
    end

    // Decoder state register.
    always_ff @(posedge i_clk) begin
        if (i_clr) r_state <= IDLE;
        else       r_state <= w_state_d;
    end

    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_ready = (r_count != '0);
    assign w_pop   = bus.rd_en && w_ready;
    // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
    assign w_wr    = w_push && (!w_full || w_pop);

    // Event storage; no reset needed since only occupied slots are ever visible.
    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_event;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a new error in the same cycle as err_clr wins.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_overflow   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
            else if (bus.err_clr)           r_overflow <= 1'b0;
            if (w_parity_err_p)             r_parity_err <= 1'b1;
            else if (bus.err_clr)           r_parity_err <= 1'b0;
            if (w_frame_err_p)              r_frame_err <= 1'b1;
            else if (bus.err_clr)           r_frame_err <= 1'b0;
        end
    end

    assign bus.data       = w_ready ? r_mem[r_rd_ptr] : '0;
    assign bus.ready      = w_ready;
    assign bus.count      = r_count;
    assign bus.overflow   = r_overflow;
    assign bus.parity_err = r_parity_err;
    assign bus.frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_keyboard_fifo.sv
// Directed bench for ps2_keyboard_fifo: latency, prefix decode, error flags, timeout,
// FIFO overflow/full push-pop, and clear mid-frame.
module tb_ps2_keyboard_fifo;

    logic clk;
    logic clr;
    logic ps2_clk;
    logic ps2_data;
    int   n_checks;
    int   n_errors;

    ps2_keyboard_fifo_if #(.FIFO_DEPTH(4)) bus ();

    ps2_keyboard_fifo #(
        .FIFO_DEPTH     (4),
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (100),
        .DECODE_EN      (1'b1)
    ) dut (
        .i_clk      (clk),
        .i_clr      (clr),
        .i_ps2_clk  (ps2_clk),
        .i_ps2_data (ps2_data),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic par_ok,
                                             input logic stop);
        logic p;
        p = ~^b;
        if (!par_ok) p = ~p;
        return {stop, p, b, 1'b0};
    endfunction

    task automatic ps2_bit(input logic b);
        @(posedge clk); #1 ps2_data = b;
        repeat (4) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (8) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) ps2_bit(f[i]);
    endtask

    // Drives the stop-bit falling edge and returns just after the third following clk edge,
    // the cycle in which the received byte is presented to the decoder.
    task automatic stop_edge(input logic b);
        @(posedge clk); #1 ps2_data = b;
        repeat (4) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic release_clk();
        repeat (6) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [10:0] f);
        send_bits(f, 10);
        stop_edge(f[10]);
        @(posedge clk); #1;
        release_clk();
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(mk_frame(b, 1'b1, 1'b1));
    endtask

    task automatic pop();
        @(posedge clk); #1 bus.rd_en = 1'b1;
        @(posedge clk); #1 bus.rd_en = 1'b0;
    endtask

    task automatic pulse_err_clr();
        @(posedge clk); #1 bus.err_clr = 1'b1;
        @(posedge clk); #1 bus.err_clr = 1'b0;
    endtask

    initial begin
        logic [10:0] f;
        n_checks    = 0;
        n_errors    = 0;
        clr         = 1'b1;
        ps2_clk     = 1'b1;
        ps2_data    = 1'b1;
        bus.rd_en   = 1'b0;
        bus.err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 clr = 1'b0;

        check("rst_data", 32'(bus.data), 32'h000);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        check("rst_perr", 32'(bus.parity_err), 32'd0);
        check("rst_ferr", 32'(bus.frame_err), 32'd0);

        // Latency of a plain byte: push seen on the 4th clk after the pin falls.
        f = mk_frame(8'h1C, 1'b1, 1'b1);
        send_bits(f, 10);
        stop_edge(f[10]);
        check("lat_not_yet", 32'(bus.ready), 32'd0);
        @(posedge clk); #1;
        check("lat_ready", 32'(bus.ready), 32'd1);
        check("lat_data", 32'(bus.data), 32'h01C);
        check("lat_count", 32'(bus.count), 32'd1);
        release_clk();
        pop();
        check("pop_ready", 32'(bus.ready), 32'd0);
        check("pop_data", 32'(bus.data), 32'h000);

        // Prefix decode.
        send_byte(8'hE0);
        check("pfx_no_push", 32'(bus.count), 32'd0);
        send_byte(8'hF0);
        send_byte(8'h75);
        check("extbrk_data", 32'(bus.data), 32'h375);
        check("extbrk_count", 32'(bus.count), 32'd1);
        send_byte(8'hF0);
        send_byte(8'h1C);
        check("brk_count", 32'(bus.count), 32'd2);
        pop();
        check("brk_data", 32'(bus.data), 32'h11C);
        pop();
        send_byte(8'hE0);
        send_byte(8'h75);
        check("ext_data", 32'(bus.data), 32'h275);
        check("ext_count", 32'(bus.count), 32'd1);
        pop();

        // Parity and framing errors.
        send_frame(mk_frame(8'h1C, 1'b0, 1'b1));
        check("perr_flag", 32'(bus.parity_err), 32'd1);
        check("perr_no_push", 32'(bus.count), 32'd0);
        check("perr_no_ferr", 32'(bus.frame_err), 32'd0);
        send_frame(mk_frame(8'h1C, 1'b1, 1'b0));
        check("ferr_flag", 32'(bus.frame_err), 32'd1);
        check("ferr_no_push", 32'(bus.count), 32'd0);
        pulse_err_clr();
        check("clr_perr", 32'(bus.parity_err), 32'd0);
        check("clr_ferr", 32'(bus.frame_err), 32'd0);

        // Stall timeout after a partial frame.
        send_bits(mk_frame(8'h2A, 1'b1, 1'b1), 6);
        repeat (130) @(posedge clk);
        #1;
        check("to_ferr", 32'(bus.frame_err), 32'd1);
        check("to_bitcnt", 32'(dut.u_rx.r_bit_cnt), 32'd0);
        check("to_no_push", 32'(bus.count), 32'd0);
        pulse_err_clr();
        send_byte(8'h2A);
        check("to_next_data", 32'(bus.data), 32'h02A);
        check("to_next_count", 32'(bus.count), 32'd1);
        pop();

        // Overflow on a full FIFO of depth 4.
        for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i));
        check("ovf_count", 32'(bus.count), 32'd4);
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("ovf_read", 32'(bus.data), 32'h010 + 32'(i));
            pop();
        end
        check("ovf_drained", 32'(bus.count), 32'd0);
        pulse_err_clr();
        check("ovf_cleared", 32'(bus.overflow), 32'd0);

        // Simultaneous push and pop while full.
        for (int i = 0; i < 4; i++) send_byte(8'h20 + 8'(i));
        f = mk_frame(8'h24, 1'b1, 1'b1);
        send_bits(f, 10);
        stop_edge(f[10]);
        bus.rd_en = 1'b1;
        @(posedge clk); #1 bus.rd_en = 1'b0;
        check("fullpp_count", 32'(bus.count), 32'd4);
        check("fullpp_no_ovf", 32'(bus.overflow), 32'd0);
        release_clk();
        for (int i = 0; i < 4; i++) begin
            check("fullpp_read", 32'(bus.data), 32'h021 + 32'(i));
            pop();
        end

        // Clear mid-frame with events queued and a flag set.
        send_byte(8'h33);
        send_byte(8'h34);
        send_frame(mk_frame(8'h55, 1'b0, 1'b1));
        check("pre_clr_count", 32'(bus.count), 32'd2);
        check("pre_clr_perr", 32'(bus.parity_err), 32'd1);
        send_bits(mk_frame(8'h77, 1'b1, 1'b1), 5);
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        check("clr_data", 32'(bus.data), 32'h000);
        check("clr_ready", 32'(bus.ready), 32'd0);
        check("clr_count", 32'(bus.count), 32'd0);
        check("clr_perr_out", 32'(bus.parity_err), 32'd0);
        check("clr_bitcnt", 32'(dut.u_rx.r_bit_cnt), 32'd0);
        send_byte(8'h1C);
        check("post_clr_data", 32'(bus.data), 32'h01C);
        check("post_clr_count", 32'(bus.count), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
